// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the stopwatch sequencing controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    ADJ  = 2'd2
  } state_e;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] SEC_MAX_TENS = 4'd5;
  localparam logic [BCD_W-1:0] SEC_MAX_ONES = 4'd9;

  localparam logic [3:0] BLANK_MIN = 4'b1100;
  localparam logic [3:0] BLANK_SEC = 4'b0011;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, sample-strobed debouncer and a
// one-clk press pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_i,
  input  logic raw_i,
  output logic press_o
);

  localparam int CNT_W = (DB_SAMPLES > 2) ? $clog2(DB_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_SAMPLES - 1);

  logic             s1_q, s2_q;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic             armed_q, armed_d;
  logic             press_q, press_d;

  // A press only counts once the button has been seen settled low after
  // reset, so a button held through reset never fires on release of rst_n.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (sample_i) begin
      if (s2_q != lvl_q) begin
        if (cnt_q == CNT_MAX) begin
          lvl_d   = s2_q;
          cnt_d   = '0;
          press_d = s2_q & armed_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
      if (!armed_q) begin
        if (s2_q) begin
          low_d = '0;
        end else if (low_q == CNT_MAX) begin
          armed_d = 1'b1;
        end else begin
          low_d = low_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      low_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: RUN/STOP/ADJ state machine, MM:SS BCD time registers
// and the adjust-mode blink mask for the display scanner.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_SAMPLES = 3,
  parameter int MAX_MIN    = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             tick_500hz,
  input  logic             btn_pause_raw,
  input  logic             btn_rst_raw,
  input  logic             sw_adj,
  input  logic             sw_sel,
  output logic [BCD_W-1:0] min_tens,
  output logic [BCD_W-1:0] min_ones,
  output logic [BCD_W-1:0] sec_tens,
  output logic [BCD_W-1:0] sec_ones,
  output logic             running,
  output logic [3:0]       blank_mask
);

  localparam logic [BCD_W-1:0] MIN_MAX_TENS = BCD_W'(MAX_MIN / 10);
  localparam logic [BCD_W-1:0] MIN_MAX_ONES = BCD_W'(MAX_MIN % 10);

  // Two-digit BCD increment that rolls over to 00 after the given maximum.
  function automatic logic [2*BCD_W-1:0] bcd_inc(
    input logic [BCD_W-1:0] tens,
    input logic [BCD_W-1:0] ones,
    input logic [BCD_W-1:0] max_tens,
    input logic [BCD_W-1:0] max_ones
  );
    if (tens == max_tens && ones == max_ones) return '0;
    if (ones == 4'd9) return {tens + 4'd1, 4'd0};
    return {tens, ones + 4'd1};
  endfunction

  logic pause_press, rst_press;
  logic adj_s1_q, adj_s2_q, sel_s1_q, sel_s2_q;

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [BCD_W-1:0] mt_q, mo_q, st_q, so_q;
  logic [BCD_W-1:0] mt_d, mo_d, st_d, so_d;
  logic [3:0]       blank_q, blank_d;
  logic [2*BCD_W-1:0] sec_next, min_next;
  logic             sec_wrap;

  btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_pause (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (tick_500hz),
    .raw_i    (btn_pause_raw),
    .press_o  (pause_press)
  );

  btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_rst (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_i (tick_500hz),
    .raw_i    (btn_rst_raw),
    .press_o  (rst_press)
  );

  assign sec_next = bcd_inc(st_q, so_q, SEC_MAX_TENS, SEC_MAX_ONES);
  assign min_next = bcd_inc(mt_q, mo_q, MIN_MAX_TENS, MIN_MAX_ONES);
  assign sec_wrap = (st_q == SEC_MAX_TENS) && (so_q == SEC_MAX_ONES);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;

    // Time update keys off the current state, so a tick that coincides
    // with a pause press in RUN still counts before the stop.
    if (rst_press) begin
      mt_d = '0;
      mo_d = '0;
      st_d = '0;
      so_d = '0;
    end else if (state_q == RUN && tick_1hz) begin
      {st_d, so_d} = sec_next;
      if (sec_wrap) {mt_d, mo_d} = min_next;
    end else if (state_q == ADJ && tick_2hz) begin
      if (sel_s2_q) {st_d, so_d} = sec_next;
      else          {mt_d, mo_d} = min_next;
    end

    if (adj_s2_q)             state_d = ADJ;
    else if (state_q == ADJ)  state_d = STOP;
    else if (rst_press)       state_d = STOP;
    else if (pause_press)     state_d = (state_q == RUN) ? STOP : RUN;

    if (state_q == ADJ && adj_s2_q) begin
      if (tick_2hz) phase_d = ~phase_q;
    end else begin
      phase_d = 1'b0;
    end

    blank_d = 4'b0000;
    if (state_d == ADJ && phase_d) blank_d = sel_s2_q ? BLANK_SEC : BLANK_MIN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj_s1_q <= 1'b0;
      adj_s2_q <= 1'b0;
      sel_s1_q <= 1'b0;
      sel_s2_q <= 1'b0;
      state_q  <= STOP;
      phase_q  <= 1'b0;
      mt_q     <= '0;
      mo_q     <= '0;
      st_q     <= '0;
      so_q     <= '0;
      blank_q  <= 4'b0000;
    end else begin
      adj_s1_q <= sw_adj;
      adj_s2_q <= adj_s1_q;
      sel_s1_q <= sw_sel;
      sel_s2_q <= sel_s1_q;
      state_q  <= state_d;
      phase_q  <= phase_d;
      mt_q     <= mt_d;
      mo_q     <= mo_d;
      st_q     <= st_d;
      so_q     <= so_d;
      blank_q  <= blank_d;
    end
  end

  assign min_tens   = mt_q;
  assign min_ones   = mo_q;
  assign sec_tens   = st_q;
  assign sec_ones   = so_q;
  assign running    = (state_q == RUN);
  assign blank_mask = blank_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a minutes/seconds reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_stopwatch_ctrl;

  localparam int DB      = 3;
  localparam int MAX_MIN = 99;
  localparam int M_STOP  = 0;
  localparam int M_RUN   = 1;
  localparam int M_ADJ   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick_1hz = 1'b0, tick_2hz = 1'b0, tick_500hz = 1'b0;
  logic btn_pause_raw = 1'b0, btn_rst_raw = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank_mask;
  logic running;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  // reference model state
  int   m_mm = 0, m_ss = 0, m_st = M_STOP;
  bit   m_phase = 1'b0;
  logic [3:0] m_blank = 4'b0000;
  bit   m_lvl[2], m_armed[2], m_pend[2];
  int   m_diff[2], m_lowc[2];
  bit   m_r1[4], m_r2[4];

  stopwatch_ctrl #(.DB_SAMPLES(DB), .MAX_MIN(MAX_MIN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_1hz      (tick_1hz),
    .tick_2hz      (tick_2hz),
    .tick_500hz    (tick_500hz),
    .btn_pause_raw (btn_pause_raw),
    .btn_rst_raw   (btn_rst_raw),
    .sw_adj        (sw_adj),
    .sw_sel        (sw_sel),
    .min_tens      (min_tens),
    .min_ones      (min_ones),
    .sec_tens      (sec_tens),
    .sec_ones      (sec_ones),
    .running       (running),
    .blank_mask    (blank_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd4(input int mm, input int ss);
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mm = 0; m_ss = 0; m_st = M_STOP; m_phase = 1'b0; m_blank = 4'b0000;
    for (int b = 0; b < 2; b++) begin
      m_lvl[b] = 1'b0; m_armed[b] = 1'b0; m_pend[b] = 1'b0;
      m_diff[b] = 0; m_lowc[b] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_r1[i] = 1'b0; m_r2[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit pp, rp, adj, sel, s;
    int old;
    bit raw[4];
    pp = m_pend[0]; rp = m_pend[1]; adj = m_r2[2]; sel = m_r2[3]; old = m_st;
    raw[0] = btn_pause_raw; raw[1] = btn_rst_raw; raw[2] = sw_adj; raw[3] = sw_sel;

    if (rp) begin
      m_mm = 0; m_ss = 0;
    end else if (old == M_RUN && tick_1hz) begin
      m_ss++;
      if (m_ss == 60) begin
        m_ss = 0;
        m_mm = (m_mm == MAX_MIN) ? 0 : m_mm + 1;
      end
    end else if (old == M_ADJ && tick_2hz) begin
      if (sel) m_ss = (m_ss + 1) % 60;
      else     m_mm = (m_mm == MAX_MIN) ? 0 : m_mm + 1;
    end

    if (adj)                m_st = M_ADJ;
    else if (old == M_ADJ)  m_st = M_STOP;
    else if (rp)            m_st = M_STOP;
    else if (pp)            m_st = (old == M_RUN) ? M_STOP : M_RUN;

    if (old == M_ADJ && adj) begin
      if (tick_2hz) m_phase = !m_phase;
    end else begin
      m_phase = 1'b0;
    end
    m_blank = (m_st == M_ADJ && m_phase) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;

    for (int b = 0; b < 2; b++) begin
      m_pend[b] = 1'b0;
      if (tick_500hz) begin
        s = m_r2[b];
        if (s != m_lvl[b]) begin
          m_diff[b]++;
          if (m_diff[b] == DB) begin
            m_lvl[b] = s;
            m_diff[b] = 0;
            m_pend[b] = s && m_armed[b];
          end
        end else begin
          m_diff[b] = 0;
        end
        if (!m_armed[b]) begin
          if (s) m_lowc[b] = 0;
          else begin
            m_lowc[b]++;
            if (m_lowc[b] == DB) m_armed[b] = 1'b1;
          end
        end
      end
    end

    for (int i = 0; i < 4; i++) begin
      m_r2[i] = m_r1[i];
      m_r1[i] = raw[i];
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("model_digits", {min_tens, min_ones, sec_tens, sec_ones}, bcd4(m_mm, m_ss));
        check("model_running", 16'(running), 16'(m_st == M_RUN));
        check("model_blank", 16'(blank_mask), 16'(m_blank));
      end
    end
  end

  initial begin : sampler
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_500hz = (cyc % 4 == 1);
      cyc++;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  task automatic pulse1(input int n);
    repeat (n) begin
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0; step();
    end
  endtask

  task automatic pulse2(input int n);
    repeat (n) begin
      tick_2hz = 1'b1; step();
      tick_2hz = 1'b0; step();
    end
  endtask

  task automatic press(input bit which_rst, input int hold_samples);
    if (which_rst) btn_rst_raw = 1'b1; else btn_pause_raw = 1'b1;
    wait_cyc(hold_samples * 4);
    btn_rst_raw = 1'b0; btn_pause_raw = 1'b0;
    wait_cyc(6 * 4);
  endtask

  task automatic goto_run(input int mm, input int ss);
    sw_adj = 1'b1; wait_cyc(4);
    press(1'b1, 5);
    sw_sel = 1'b0; wait_cyc(3);
    pulse2(mm);
    sw_sel = 1'b1; wait_cyc(3);
    pulse2(ss);
    sw_adj = 1'b0; wait_cyc(4);
    press(1'b0, 5);
  endtask

  task automatic lit(input string name, input logic [15:0] dig, input bit run, input logic [3:0] blank);
    @(negedge clk);
    check({name, "_digits"}, {min_tens, min_ones, sec_tens, sec_ones}, dig);
    check({name, "_running"}, 16'(running), 16'(run));
    check({name, "_blank"}, 16'(blank_mask), 16'(blank));
  endtask

  initial begin : stim
    logic [15:0] bounce;
    logic [7:0]  sec_exp[3];
    logic [3:0]  blk_exp[3];
    bit found;
    bounce = 16'b0110_1101_1001_0110;
    sec_exp[0] = 8'h59; sec_exp[1] = 8'h00; sec_exp[2] = 8'h01;
    blk_exp[0] = 4'b0011; blk_exp[1] = 4'b0000; blk_exp[2] = 4'b0011;

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    lit("reset", 16'h0000, 1'b0, 4'b0000);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(8 * 4);

    // 1: start, count 61 s, stop
    press(1'b0, 5);
    lit("t1_started", 16'h0000, 1'b1, 4'b0000);
    pulse1(61);
    lit("t1_0101", 16'h0101, 1'b1, 4'b0000);
    press(1'b0, 5);
    pulse1(3);
    lit("t1_frozen", 16'h0101, 1'b0, 4'b0000);

    // 2: 99:59 -> 00:00 still running; 09:59 -> 10:00
    goto_run(99, 59);
    lit("t2_preset", 16'h9959, 1'b1, 4'b0000);
    pulse1(1);
    lit("t2_wrap", 16'h0000, 1'b1, 4'b0000);
    goto_run(9, 59);
    pulse1(1);
    lit("t2_carry", 16'h1000, 1'b1, 4'b0000);

    // 3: bouncing press then a single-sample glitch
    for (int i = 0; i < 16; i++) begin
      btn_pause_raw = bounce[i];
      step();
    end
    btn_pause_raw = 1'b1;
    wait_cyc(6 * 4);
    btn_pause_raw = 1'b0;
    wait_cyc(6 * 4);
    lit("t3_one_press", 16'h1000, 1'b0, 4'b0000);
    btn_pause_raw = 1'b1; wait_cyc(4);
    btn_pause_raw = 1'b0; wait_cyc(8 * 4);
    lit("t3_glitch", 16'h1000, 1'b0, 4'b0000);

    // 4: adjust seconds 58 -> 59, 00, 01 with blink
    sw_adj = 1'b1; wait_cyc(4);
    press(1'b1, 5);
    sw_sel = 1'b1; wait_cyc(3);
    pulse2(58);
    lit("t4_58", 16'h0058, 1'b0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick_2hz = 1'b1; step();
      tick_2hz = 1'b0;
      lit("t4_adj", {8'h00, sec_exp[i]}, 1'b0, blk_exp[i]);
    end
    sw_adj = 1'b0; wait_cyc(4);
    lit("t4_exit", 16'h0001, 1'b0, 4'b0000);

    // 5: reset press with tick in RUN; reset with pause from STOP
    goto_run(12, 34);
    lit("t5_preset", 16'h1234, 1'b1, 4'b0000);
    btn_rst_raw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_pend[1]) found = 1'b1;
    end
    if (!found) begin
      n_total++; n_bad++;
      $display("FAIL t5_rst_wait: no reset press seen within 200 cycles, expected one");
    end else begin
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0;
    end
    wait_cyc(5 * 4);
    btn_rst_raw = 1'b0; wait_cyc(6 * 4);
    lit("t5_rst_tick", 16'h0000, 1'b0, 4'b0000);
    btn_rst_raw = 1'b1; btn_pause_raw = 1'b1;
    wait_cyc(5 * 4);
    btn_rst_raw = 1'b0; btn_pause_raw = 1'b0;
    wait_cyc(6 * 4);
    lit("t5_rst_pause", 16'h0000, 1'b0, 4'b0000);

    // 6: async reset mid-run with pause held
    goto_run(5, 17);
    lit("t6_preset", 16'h0517, 1'b1, 4'b0000);
    btn_pause_raw = 1'b1;
    wait_cyc(5);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);
    check("t6_async_running", 16'(running), 16'h0000);
    check("t6_async_blank", 16'(blank_mask), 16'h0000);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(20 * 4);
    lit("t6_held", 16'h0000, 1'b0, 4'b0000);
    btn_pause_raw = 1'b0;
    wait_cyc(8 * 4);
    press(1'b0, 5);
    lit("t6_repress", 16'h0000, 1'b1, 4'b0000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
